// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment patterns, scan-decoder FSM encoding and enable helpers
package seg7_pkg;

    // Active-low segment patterns, a at bit 6 through g at bit 0; shared with the driver.
    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
        SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
    };

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    function automatic logic is_one_cold(input logic [3:0] v);
        return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
    endfunction

    function automatic logic [1:0] onecold_to_idx(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/mux_seg_decoder_4dig_if.sv
// rtl/mux_seg_decoder_4dig_if.sv - scanned common-anode display bus (segments plus digit enables)
interface mux_seg_decoder_4dig_if;
    logic [6:0] segments;
    logic [3:0] ndig_en;

    modport master (output segments, output ndig_en);
    modport slave  (input  segments, input  ndig_en);
endinterface

// File: rtl/seg7_to_hex.sv
// rtl/seg7_to_hex.sv - active-low 7-segment pattern to hex code with invalid-pattern flag
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] code,
    output logic       invalid
);

    always_comb begin
        code    = 4'd0;
        invalid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_TABLE[i]) begin
                code    = 4'(i);
                invalid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_seg_decoder_4dig.sv
// rtl/mux_seg_decoder_4dig.sv - recovers four digit codes from a scanned 7-segment display bus
module mux_seg_decoder_4dig
    import seg7_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int MATCH_COUNT   = 2,
    parameter int TIMEOUT_BITS  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    mux_seg_decoder_4dig_if.slave   disp,
    output logic [3:0]              bcd0,
    output logic [3:0]              bcd1,
    output logic [3:0]              bcd2,
    output logic [3:0]              bcd3,
    output logic [3:0]              dig_valid,
    output logic [3:0]              seg_err,
    output logic                    frame_done
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] MATCH_N     = 4'(MATCH_COUNT);

    logic [6:0] seg_r;
    logic [3:0] en_r;
    logic [3:0] en_q;
    logic [1:0] state;
    logic [1:0] state_nx;
    logic [1:0] restart_state;
    logic [7:0] settle_cnt;
    logic [7:0] settle_nx;
    logic [7:0] settle_inc;
    logic       en_sel;
    logic       en_chg;
    logic       do_cap;
    logic [1:0] cap_idx;

    logic [3:0]              cand      [4];
    logic [3:0]              match_cnt [4];
    logic [3:0]              bcd       [4];
    logic [TIMEOUT_BITS-1:0] timer     [4];

    logic [3:0] dec_code;
    logic       dec_invalid;
    logic [3:0] sel_cand;
    logic [3:0] sel_cnt;
    logic [3:0] cnt_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r <= 7'h7F;
            en_r  <= 4'hF;
            en_q  <= 4'hF;
        end else begin
            seg_r <= disp.segments;
            en_r  <= disp.ndig_en;
            en_q  <= en_r;
        end
    end

    assign en_sel     = is_one_cold(en_r);
    assign en_chg     = (en_r != en_q);
    assign settle_inc = settle_cnt + 8'd1;
    assign cap_idx    = onecold_to_idx(en_r);

    // A one-cycle settle window means the detection cycle itself is enough.
    always_comb begin
        restart_state = ST_IDLE;
        if (en_sel)
            restart_state = (SETTLE_CYCLES == 1) ? ST_CAPTURE : ST_SETTLE;
    end

    always_comb begin
        state_nx  = state;
        settle_nx = settle_cnt;
        do_cap    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en_sel) begin
                    state_nx  = restart_state;
                    settle_nx = 8'd0;
                end
            end
            ST_SETTLE: begin
                if (en_chg) begin
                    state_nx  = restart_state;
                    settle_nx = 8'd0;
                end else if (settle_inc == SETTLE_LAST) begin
                    state_nx = ST_CAPTURE;
                end else begin
                    settle_nx = settle_inc;
                end
            end
            ST_CAPTURE: begin
                if (en_chg) begin
                    state_nx  = restart_state;
                    settle_nx = 8'd0;
                end else begin
                    do_cap   = 1'b1;
                    state_nx = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (en_chg) begin
                    state_nx  = restart_state;
                    settle_nx = 8'd0;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            settle_cnt <= 8'd0;
        end else begin
            state      <= state_nx;
            settle_cnt <= settle_nx;
        end
    end

    seg7_to_hex u_dec (
        .pattern (seg_r),
        .code    (dec_code),
        .invalid (dec_invalid)
    );

    assign sel_cand = cand[cap_idx];
    assign sel_cnt  = match_cnt[cap_idx];

    always_comb begin
        cnt_nx = 4'd1;
        if (dec_code == sel_cand)
            cnt_nx = (sel_cnt >= MATCH_N) ? MATCH_N : sel_cnt + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done <= 1'b0;
            dig_valid  <= 4'h0;
            seg_err    <= 4'h0;
            for (int n = 0; n < 4; n++) begin
                cand[n]      <= 4'd0;
                match_cnt[n] <= 4'd0;
                bcd[n]       <= 4'd0;
                timer[n]     <= '0;
            end
        end else begin
            frame_done <= do_cap && (cap_idx == 2'd3);
            for (int n = 0; n < 4; n++) begin
                if (do_cap && (cap_idx == 2'(n))) begin
                    timer[n] <= '0;
                    if (dec_invalid) begin
                        seg_err[n]   <= 1'b1;
                        match_cnt[n] <= 4'd0;
                    end else begin
                        seg_err[n]   <= 1'b0;
                        cand[n]      <= dec_code;
                        match_cnt[n] <= cnt_nx;
                        if (cnt_nx == MATCH_N) begin
                            bcd[n]       <= dec_code;
                            dig_valid[n] <= 1'b1;
                        end
                    end
                end else if (timer[n] == {TIMEOUT_BITS{1'b1}}) begin
                    // Stale digit: keep the last code but stop vouching for it.
                    dig_valid[n] <= 1'b0;
                end else begin
                    timer[n] <= timer[n] + TIMEOUT_BITS'(1);
                end
            end
        end
    end

    assign bcd0 = bcd[0];
    assign bcd1 = bcd[1];
    assign bcd2 = bcd[2];
    assign bcd3 = bcd[3];

endmodule

// File: tb/tb_mux_seg_decoder_4dig.sv
// tb/tb_mux_seg_decoder_4dig.sv - scoreboard bench for the 4-digit 7-segment scan decoder
module tb_mux_seg_decoder_4dig;

    localparam int S  = 4;
    localparam int M  = 2;
    localparam int TB = 8;
    localparam int TO_HOLD = (1 << TB) + 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] bcd0, bcd1, bcd2, bcd3;
    logic [3:0] dig_valid, seg_err;
    logic       frame_done;

    mux_seg_decoder_4dig_if bus ();

    mux_seg_decoder_4dig #(
        .SETTLE_CYCLES (S),
        .MATCH_COUNT   (M),
        .TIMEOUT_BITS  (TB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .disp       (bus),
        .bcd0       (bcd0),
        .bcd1       (bcd1),
        .bcd2       (bcd2),
        .bcd3       (bcd3),
        .dig_valid  (dig_valid),
        .seg_err    (seg_err),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] bcd;
        logic [3:0]  valid;
        logic [3:0]  err;
        logic        fd;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         fd_seen = 0;
    int         fd_exp = 0;
    logic [6:0] pat_tbl [16];
    logic [3:0] m_cand [4];
    logic [3:0] m_cnt  [4];
    logic [3:0] m_bcd  [4];
    logic [3:0] m_valid;
    logic [3:0] m_err;
    logic [3:0] prev_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t snap(input int c, input logic fd);
        exp_t e;
        e.cyc   = c;
        e.bcd   = {m_bcd[3], m_bcd[2], m_bcd[1], m_bcd[0]};
        e.valid = m_valid;
        e.err   = m_err;
        e.fd    = fd;
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cand[i] = 4'd0;
            m_cnt[i]  = 4'd0;
            m_bcd[i]  = 4'd0;
        end
        m_valid = 4'h0;
        m_err   = 4'h0;
        prev_en = 4'hF;
    endtask

    task automatic model_capture(input int d, input logic [6:0] seg);
        int code;
        code = -1;
        for (int i = 0; i < 16; i++)
            if (pat_tbl[i] == seg) code = i;
        if (code < 0) begin
            m_err[d] = 1'b1;
            m_cnt[d] = 4'd0;
        end else begin
            m_err[d] = 1'b0;
            if (4'(code) == m_cand[d]) begin
                if (m_cnt[d] < 4'(M)) m_cnt[d] = m_cnt[d] + 4'd1;
            end else begin
                m_cand[d] = 4'(code);
                m_cnt[d]  = 4'd1;
            end
            if (m_cnt[d] == 4'(M)) begin
                m_bcd[d]   = 4'(code);
                m_valid[d] = 1'b1;
            end
        end
    endtask

    // Drive one enable period of 'hold' clock edges; predict the capture it should cause.
    task automatic show(input logic [3:0] en, input logic [6:0] seg, input int hold);
        int e_out;
        int d;
        @(negedge clk);
        bus.ndig_en  = en;
        bus.segments = seg;
        e_out = cyc + S + 2;
        if ($countones(~en) == 1 && en != prev_en && hold >= S + 1) begin
            d = 0;
            for (int i = 0; i < 4; i++)
                if (!en[i]) d = i;
            sb.push_back(snap(e_out - 1, 1'b0));
            model_capture(d, seg);
            sb.push_back(snap(e_out, d == 3));
            if (d == 3) fd_exp++;
        end
        prev_en = en;
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic drain();
        repeat (S + 4) @(negedge clk);
    endtask

    task automatic frame_1_2_3_a();
        logic [6:0] pats [4];
        pats[0] = pat_tbl[1];
        pats[1] = pat_tbl[2];
        pats[2] = pat_tbl[3];
        pats[3] = pat_tbl[10];
        for (int d = 0; d < 4; d++)
            show(~(4'b0001 << d), pats[d], 8);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (frame_done) fd_seen++;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc != cyc) check("mon_late", cyc, e.cyc);
            check($sformatf("mon_bcd@%0d", cyc), {bcd3, bcd2, bcd1, bcd0}, e.bcd);
            check($sformatf("mon_valid@%0d", cyc), dig_valid, e.valid);
            check($sformatf("mon_err@%0d", cyc), seg_err, e.err);
            check($sformatf("mon_fd@%0d", cyc), frame_done, e.fd);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        pat_tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        bus.ndig_en  = 4'hF;
        bus.segments = 7'h7F;
        model_reset();

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_bcd", {bcd3, bcd2, bcd1, bcd0}, 16'h0);
        check("rst_valid", dig_valid, 4'h0);
        check("rst_err", seg_err, 4'h0);
        check("rst_fd", frame_done, 1'b0);
        rst = 1'b0;

        // Two enable periods of digit 1 showing "2": output only after the second.
        show(4'b1101, 7'b0010010, S + 1);
        show(4'b1111, 7'h7F, 3);
        show(4'b1101, 7'b0010010, S + 1);
        show(4'b1111, 7'h7F, 3);
        drain();
        check("gap_bcd1", bcd1, 4'd2);
        check("gap_valid", dig_valid, 4'b0010);

        frame_1_2_3_a();
        frame_1_2_3_a();
        drain();
        check("frame_bcd", {bcd3, bcd2, bcd1, bcd0}, 16'hA321);
        check("frame_valid", dig_valid, 4'hF);
        check("frame_err", seg_err, 4'h0);

        // Short glitch onto digit 1 with a blank pattern must not be captured.
        show(4'b1110, pat_tbl[1], 8);
        show(4'b1101, 7'b1111111, 2);
        show(4'b1110, pat_tbl[1], 8);
        drain();
        check("glitch_err", seg_err, 4'h0);

        show(4'b1011, 7'b1111110, 8);
        show(4'b1111, 7'h7F, 2);
        drain();
        check("inv_err", seg_err, 4'b0100);
        check("inv_bcd2", bcd2, 4'd3);
        show(4'b1011, 7'b0000110, 8);
        drain();
        check("inv_clear", seg_err, 4'h0);

        show(4'b1111, 7'h7F, TO_HOLD);
        check("to_none_valid", dig_valid, 4'h0);
        check("to_none_bcd", {bcd3, bcd2, bcd1, bcd0}, 16'hA321);
        m_valid = 4'h0;

        frame_1_2_3_a();
        frame_1_2_3_a();
        drain();
        check("refill_valid", dig_valid, 4'hF);
        show(4'b1100, pat_tbl[8], TO_HOLD);
        repeat (4) @(negedge clk);
        check("to_two_valid", dig_valid, 4'h0);
        check("to_two_bcd", {bcd3, bcd2, bcd1, bcd0}, 16'hA321);
        check("to_two_err", seg_err, 4'h0);
        m_valid = 4'h0;

        // Reset while digit 3 is still settling.
        show(4'b0111, pat_tbl[5], 2);
        rst = 1'b1;
        bus.ndig_en  = 4'hF;
        bus.segments = 7'h7F;
        @(negedge clk);
        check("mid_rst_bcd", {bcd3, bcd2, bcd1, bcd0}, 16'h0);
        check("mid_rst_valid", dig_valid, 4'h0);
        check("mid_rst_err", seg_err, 4'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drain();

        check("fd_count", fd_seen, fd_exp);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
